// File: rtl/ibex_pkg.sv
// -----------------------------------------------------------------------------
// ibex_pkg
// Shared types for the EX-to-writeback result buffer.
//   ex_src_e      : which execution unit produced a result
//   ex_wb_entry_t : one buffered result (data, destination, write-enable, source)
//   rdWrites()    : a result only writes the register file when rd is not x0
// -----------------------------------------------------------------------------
package ibex_pkg;

   typedef enum logic [1:0] {
      EX_SRC_ALU     = 2'd0,
      EX_SRC_MULTDIV = 2'd1,
      EX_SRC_IPM     = 2'd2
   } ex_src_e;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        rf_we;
      ex_src_e     src;
   } ex_wb_entry_t;

   // x0 is hardwired to zero, so a write aimed at it is dropped at capture time
   function automatic logic rdWrites(input logic [4:0] rd, input logic we);
      return we & (rd != 5'd0);
   endfunction

endpackage

// File: rtl/ibex_ex_wb_fwd_match.sv
// -----------------------------------------------------------------------------
// ibex_ex_wb_fwd_match
// Finds the youngest buffered result that writes the register one ID-stage
// operand is reading, so ID can use it before it reaches the register file.
//   head_idx_i    : storage index of the oldest entry
//   entry_valid_i : per-entry "valid and writes the register file"
//   entry_rd_i    : per-entry destination register, 5 bits each
//   entry_data_i  : per-entry result, 32 bits each
//   rs_addr_i     : operand register address
//   hit_o/data_o  : match flag and forwarded data (zero on no match)
// -----------------------------------------------------------------------------
module ibex_ex_wb_fwd_match #(
   parameter int unsigned Depth = 2
) (
   input  logic [$clog2(Depth)-1:0] head_idx_i,
   input  logic [Depth-1:0]         entry_valid_i,
   input  logic [Depth*5-1:0]       entry_rd_i,
   input  logic [Depth*32-1:0]      entry_data_i,
   input  logic [4:0]               rs_addr_i,
   output logic                     hit_o,
   output logic [31:0]              data_o
);

   localparam int unsigned IdxW = $clog2(Depth);

   logic [IdxW-1:0] scanIdx;

   // Valid entries are contiguous starting at the head, so scanning from the
   // oldest to the youngest and letting each later match overwrite the earlier
   // one leaves the youngest match on the outputs. x0 is never forwarded.
   always_comb begin
      hit_o   = 1'b0;
      data_o  = 32'd0;
      scanIdx = head_idx_i;
      for (int i = 0; i < int'(Depth); i++) begin
         scanIdx = head_idx_i + IdxW'(i);
         if ((rs_addr_i != 5'd0) && entry_valid_i[scanIdx] &&
             (entry_rd_i[32'(scanIdx)*5 +: 5] == rs_addr_i)) begin
            hit_o  = 1'b1;
            data_o = entry_data_i[32'(scanIdx)*32 +: 32];
         end
      end
   end

endmodule

// File: rtl/ibex_ex_wb_buffer.sv
// -----------------------------------------------------------------------------
// ibex_ex_wb_buffer
// Small FIFO between EX completion and the register-file writeback port, with
// optional forwarding of not-yet-written results to the ID operand muxes.
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   ex_valid_i / ex_ready_o  : push handshake (ex_ready_o is registered)
//   ex_result_i, ex_rd_addr_i, ex_rf_we_i, ex_src_i : pushed entry fields
//   flush_i                  : drop every buffered entry
//   wb_valid_o / wb_ready_i  : pop handshake for the head entry
//   wb_result_o, wb_rd_addr_o, wb_rf_we_o, wb_src_o : head entry fields
//   fwd_rs_addr_i            : {rs2, rs1} operand addresses
//   fwd_hit_o, fwd_data_o    : per-operand forwarding hit / data
//                              (bit 0 and bits [31:0] belong to rs1)
//
// Configuration macro: IBEX_EX_WB_FWD_EN builds the forwarding match logic;
// without it the forwarding outputs are tied to zero.
// Depth must be 2 or 4.
// -----------------------------------------------------------------------------
module ibex_ex_wb_buffer
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic [31:0] ex_result_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_rf_we_i,
   input  logic [1:0]  ex_src_i,
   input  logic        flush_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [31:0] wb_result_o,
   output logic [4:0]  wb_rd_addr_o,
   output logic        wb_rf_we_o,
   output logic [1:0]  wb_src_o,
   input  logic [9:0]  fwd_rs_addr_i,
   output logic [1:0]  fwd_hit_o,
   output logic [63:0] fwd_data_o
);

   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned PtrW = IdxW + 1;

   ex_wb_entry_t    entries_q [Depth];
   logic [Depth-1:0] valid_q;
   logic [PtrW-1:0] wrPtr_q, wrPtr_d;
   logic [PtrW-1:0] rdPtr_q, rdPtr_d;
   logic            exReady_q, exReady_d;
   logic            push, pop, fullNext;
   logic [IdxW-1:0] wrIdx, rdIdx;
   ex_wb_entry_t    newEntry, headEntry;

   assign wrIdx     = wrPtr_q[IdxW-1:0];
   assign rdIdx     = rdPtr_q[IdxW-1:0];
   assign headEntry = entries_q[rdIdx];

   assign push = ex_valid_i & exReady_q;
   assign pop  = wb_valid_o & wb_ready_i;

   assign newEntry.result = ex_result_i;
   assign newEntry.rd     = ex_rd_addr_i;
   assign newEntry.rf_we  = rdWrites(ex_rd_addr_i, ex_rf_we_i);
   assign newEntry.src    = ex_src_e'(ex_src_i);

   // Next pointer values. The extra MSB on each pointer flips on wrap, which
   // is what separates "full" (low bits equal, MSBs differ) from "empty"
   // (pointers identical). Ready is derived from the next pointers so it can
   // be registered; a pop while full therefore only reopens ready one cycle
   // later, and wb_ready_i never reaches ex_ready_o combinationally.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (push) wrPtr_d = wrPtr_q + PtrW'(1);
         if (pop)  rdPtr_d = rdPtr_q + PtrW'(1);
      end
      fullNext  = (wrPtr_d[IdxW-1:0] == rdPtr_d[IdxW-1:0]) &&
                  (wrPtr_d[IdxW] != rdPtr_d[IdxW]);
      exReady_d = ~fullNext;
   end

   // Pointer and ready registers. Reset leaves the buffer empty and ready.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         exReady_q <= 1'b1;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         exReady_q <= exReady_d;
      end
   end

   // Per-entry valid bits. Push and pop never address the same slot in one
   // cycle: that would need the buffer to be both full (no push allowed)
   // and empty (nothing to pop). Flush wins over both.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
      end else begin
         if (push) valid_q[wrIdx] <= 1'b1;
         if (pop)  valid_q[rdIdx] <= 1'b0;
      end
   end

   // Entry storage. Only reset clears the payload; a flush just invalidates,
   // and the stale head contents are hidden behind wb_valid_o=0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            entries_q[i] <= '0;
         end
      end else if (push && !flush_i) begin
         entries_q[wrIdx] <= newEntry;
      end
   end

   assign ex_ready_o   = exReady_q;
   assign wb_valid_o   = valid_q[rdIdx];
   assign wb_result_o  = headEntry.result;
   assign wb_rd_addr_o = headEntry.rd;
   assign wb_rf_we_o   = headEntry.rf_we;
   assign wb_src_o     = headEntry.src;

`ifdef IBEX_EX_WB_FWD_EN
   logic [Depth-1:0]    fwdValid;
   logic [Depth*5-1:0]  fwdRd;
   logic [Depth*32-1:0] fwdData;

   // Flatten storage for the matchers. An entry is a forwarding candidate
   // only when it is valid and actually writes the register file; the head
   // stays a candidate in the cycle it is popped because valid_q is a
   // register.
   always_comb begin
      fwdValid = '0;
      fwdRd    = '0;
      fwdData  = '0;
      for (int i = 0; i < int'(Depth); i++) begin
         fwdValid[i]        = valid_q[i] & entries_q[i].rf_we;
         fwdRd[i*5 +: 5]    = entries_q[i].rd;
         fwdData[i*32 +: 32] = entries_q[i].result;
      end
   end

   ibex_ex_wb_fwd_match #(.Depth(Depth)) u_fwd_rs1 (
      .head_idx_i    (rdIdx),
      .entry_valid_i (fwdValid),
      .entry_rd_i    (fwdRd),
      .entry_data_i  (fwdData),
      .rs_addr_i     (fwd_rs_addr_i[4:0]),
      .hit_o         (fwd_hit_o[0]),
      .data_o        (fwd_data_o[31:0])
   );

   ibex_ex_wb_fwd_match #(.Depth(Depth)) u_fwd_rs2 (
      .head_idx_i    (rdIdx),
      .entry_valid_i (fwdValid),
      .entry_rd_i    (fwdRd),
      .entry_data_i  (fwdData),
      .rs_addr_i     (fwd_rs_addr_i[9:5]),
      .hit_o         (fwd_hit_o[1]),
      .data_o        (fwd_data_o[63:32])
   );
`else
   // Forwarding is not built; the ports stay so the parent is unchanged.
   logic [9:0] unused_fwd_rs_addr;
   assign unused_fwd_rs_addr = fwd_rs_addr_i;
   assign fwd_hit_o          = 2'b00;
   assign fwd_data_o         = 64'd0;
`endif

endmodule

// File: tb/tb_ibex_ex_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_ibex_ex_wb_buffer
// Drives directed and random traffic into ibex_ex_wb_buffer (Depth=2). The
// stimulus side records every accepted push in a queue; a monitor on the
// falling edge compares the DUT against that queue, which is treated as an
// ordinary FIFO of results.
// -----------------------------------------------------------------------------
module tb_ibex_ex_wb_buffer;

   localparam int Depth = 2;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
      logic [1:0]  src;
   } expEntry_t;

   logic        clk;
   logic        rst_ni;
   logic        ex_valid_i;
   logic        ex_ready_o;
   logic [31:0] ex_result_i;
   logic [4:0]  ex_rd_addr_i;
   logic        ex_rf_we_i;
   logic [1:0]  ex_src_i;
   logic        flush_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [31:0] wb_result_o;
   logic [4:0]  wb_rd_addr_o;
   logic        wb_rf_we_o;
   logic [1:0]  wb_src_o;
   logic [9:0]  fwd_rs_addr_i;
   logic [1:0]  fwd_hit_o;
   logic [63:0] fwd_data_o;

   expEntry_t expQ[$];
   bit        mReady = 1'b1;
   bit        pend   = 1'b0;
   int        vectors = 0;
   int        miscompares = 0;
   int        checks = 0;

   ibex_ex_wb_buffer #(.Depth(Depth)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .ex_valid_i    (ex_valid_i),
      .ex_ready_o    (ex_ready_o),
      .ex_result_i   (ex_result_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_rf_we_i    (ex_rf_we_i),
      .ex_src_i      (ex_src_i),
      .flush_i       (flush_i),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready_i),
      .wb_result_o   (wb_result_o),
      .wb_rd_addr_o  (wb_rd_addr_o),
      .wb_rf_we_o    (wb_rf_we_o),
      .wb_src_o      (wb_src_o),
      .fwd_rs_addr_i (fwd_rs_addr_i),
      .fwd_hit_o     (fwd_hit_o),
      .fwd_data_o    (fwd_data_o)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison; every mismatch prints a single FAIL line
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge. A push is accepted
   // when the buffer has room, so the expected entry goes into the scoreboard
   // now and becomes visible to the monitor one edge later.
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] rd,
                                input logic we, input logic [1:0] src, input logic wbr,
                                input logic fl, input logic [4:0] rs1, input logic [4:0] rs2);
      expEntry_t e;
      @(posedge clk);
      #1;
      ex_valid_i    = v;
      ex_result_i   = d;
      ex_rd_addr_i  = rd;
      ex_rf_we_i    = we;
      ex_src_i      = src;
      wb_ready_i    = wbr;
      flush_i       = fl;
      fwd_rs_addr_i = {rs2, rs1};
      vectors++;
      if (v && mReady && !fl) begin
         e.result = d;
         e.rd     = rd;
         e.we     = we && (rd != 5'd0);
         e.src    = src;
         expQ.push_back(e);
         pend = 1'b1;
      end
   endtask

   task automatic idle(input logic wbr, input logic [4:0] rs1, input logic [4:0] rs2);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 2'd0, wbr, 1'b0, rs1, rs2);
   endtask

   // Reset values are checked directly, right after reset takes effect
   task automatic checkResetValues(input string tag);
      checkOutput({tag, " ex_ready"}, 32'(ex_ready_o), 32'd1);
      checkOutput({tag, " wb_valid"}, 32'(wb_valid_o), 32'd0);
      checkOutput({tag, " wb_result"}, wb_result_o, 32'd0);
      checkOutput({tag, " wb_rd"}, 32'(wb_rd_addr_o), 32'd0);
      checkOutput({tag, " wb_we"}, 32'(wb_rf_we_o), 32'd0);
      checkOutput({tag, " wb_src"}, 32'(wb_src_o), 32'd0);
      checkOutput({tag, " fwd_hit"}, 32'(fwd_hit_o), 32'd0);
      checkOutput({tag, " fwd_data0"}, fwd_data_o[31:0], 32'd0);
   endtask

   // Assert reset in the middle of a cycle and confirm the outputs drop
   // before any clock edge; the model forgets everything it held.
   task automatic resetMidCycle();
      @(posedge clk);
      #1;
      ex_valid_i    = 1'b0;
      wb_ready_i    = 1'b0;
      flush_i       = 1'b0;
      fwd_rs_addr_i = {5'd9, 5'd7};
      vectors++;
      #2;
      rst_ni = 1'b0;
      #1;
      checkResetValues("async_reset");
      expQ.delete();
      pend   = 1'b0;
      mReady = 1'b1;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   // Monitor: on every falling edge compare against the scoreboard, then
   // advance the model across the coming rising edge.
   initial begin
      forever begin
         int vis;
         logic        expHit;
         logic [31:0] expData;
         logic [4:0]  rs;
         @(negedge clk);
         vis = expQ.size() - (pend ? 1 : 0);
         checkOutput("ex_ready", 32'(ex_ready_o), 32'(mReady));
         checkOutput("wb_valid", 32'(wb_valid_o), 32'(vis > 0));
         if (vis > 0) begin
            checkOutput("wb_result", wb_result_o, expQ[0].result);
            checkOutput("wb_rd", 32'(wb_rd_addr_o), 32'(expQ[0].rd));
            checkOutput("wb_we", 32'(wb_rf_we_o), 32'(expQ[0].we));
            checkOutput("wb_src", 32'(wb_src_o), 32'(expQ[0].src));
         end
         for (int k = 0; k < 2; k++) begin
            rs      = (k == 0) ? fwd_rs_addr_i[4:0] : fwd_rs_addr_i[9:5];
            expHit  = 1'b0;
            expData = 32'd0;
`ifdef IBEX_EX_WB_FWD_EN
            if (rs != 5'd0) begin
               for (int i = 0; i < vis; i++) begin
                  if (expQ[i].we && expQ[i].rd == rs) begin
                     expHit  = 1'b1;
                     expData = expQ[i].result;
                  end
               end
            end
`endif
            checkOutput(k == 0 ? "fwd_hit_rs1" : "fwd_hit_rs2", 32'(fwd_hit_o[k]), 32'(expHit));
            checkOutput(k == 0 ? "fwd_data_rs1" : "fwd_data_rs2",
                        (k == 0) ? fwd_data_o[31:0] : fwd_data_o[63:32], expData);
         end
         if (!rst_ni || flush_i) begin
            expQ.delete();
         end else if (vis > 0 && wb_ready_i) begin
            void'(expQ.pop_front());
         end
         pend   = 1'b0;
         mReady = (expQ.size() < Depth);
      end
   end

   // Directed scenarios first, then random traffic
   initial begin
      rst_ni        = 1'b0;
      ex_valid_i    = 1'b0;
      ex_result_i   = 32'h0;
      ex_rd_addr_i  = 5'd0;
      ex_rf_we_i    = 1'b0;
      ex_src_i      = 2'd0;
      flush_i       = 1'b0;
      wb_ready_i    = 1'b0;
      fwd_rs_addr_i = 10'd0;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst_ni = 1'b1;

      // Single push held in the buffer; forwarding sees rd=5
      applyStimulus(1'b1, 32'h1234_5678, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0, 5'd0);
      idle(1'b0, 5'd5, 5'd0);

      // Fill, attempt a push while full, pop while EX keeps offering
      applyStimulus(1'b1, 32'h0000_000A, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 5'd5, 5'd7);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 5'd7, 5'd3);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 2'd1, 1'b1, 1'b0, 5'd3, 5'd5);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 5'd3, 5'd7);
      repeat (3) idle(1'b1, 5'd3, 5'd7);

      // Two writes to the same register: the younger one forwards
      applyStimulus(1'b1, 32'h0000_000A, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b1, 32'h0000_000B, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 5'd7, 5'd0);
      idle(1'b0, 5'd7, 5'd7);

      // Flush a full buffer while EX offers a new result
      applyStimulus(1'b1, 32'h5555_5555, 5'd4, 1'b1, 2'd0, 1'b1, 1'b1, 5'd7, 5'd4);
      idle(1'b0, 5'd7, 5'd4);

      // Result aimed at x0 loses its write-enable and never forwards
      applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 5'd0);
      idle(1'b0, 5'd0, 5'd0);
      idle(1'b1, 5'd0, 5'd0);

      // Asynchronous reset with two entries held, then a fresh push
      applyStimulus(1'b1, 32'h1111_1111, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b1, 32'h2222_2222, 5'd9, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0, 5'd0);
      resetMidCycle();
      applyStimulus(1'b1, 32'h0000_C0DE, 5'd9, 1'b1, 2'd0, 1'b0, 1'b0, 5'd9, 5'd0);
      idle(1'b0, 5'd9, 5'd0);
      idle(1'b1, 5'd9, 5'd0);

      // Random traffic over a small register range so forwarding hits often
      for (int n = 0; n < 2000; n++) begin
         applyStimulus($urandom_range(0, 9) < 6, $urandom(), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                       $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
      repeat (4) idle(1'b1, 5'd0, 5'd0);

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
